// File: rtl/instruction_stream_rom.sv
// rtl/instruction_stream_rom.sv - instruction memory loaded over a valid/ready stream, fetched with one-cycle latency
// Optional feature macro: INSTR_PARITY_EN (per-word parity capture on load, recheck on fetch)
module instruction_stream_rom #(
  parameter int           W    = 9,
  parameter int           D    = 12,
  parameter logic [W-1:0] FILL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         load_valid,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
`ifdef INSTR_PARITY_EN
  input  logic         load_parity,
  output logic         parity_err,
`endif
  output logic         load_ready,
  input  logic [D-1:0] programCounter,
  input  logic         fetch_en,
  output logic [W-1:0] machineCode,
  output logic         code_valid,
  output logic         loaded,
  output logic [D:0]   load_count,
  output logic         load_err
);

`ifdef INSTR_PARITY_EN
  localparam int EW = W + 1;
`else
  localparam int EW = W;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t         state_q;
  logic           load_ready_q;
  logic           loaded_q;
  logic [D:0]     count_q;
  logic [D:0]     count_d;
  logic           load_err_q;
  logic [W-1:0]   code_q;
  logic           code_valid_q;
`ifdef INSTR_PARITY_EN
  logic           parity_err_q;
`endif

  logic [EW-1:0]  core [0:(2**D)-1];
  logic [EW-1:0]  wr_entry;
  logic [EW-1:0]  rd_entry;
  logic           xfer;
  logic           final_word;
  logic           in_range;

  // Handshake decode, next count, and the entry written/read this cycle
  always_comb begin
    xfer       = (state_q == LOAD) && load_valid && load_ready_q;
    // count_q never exceeds 2**D-1 while in LOAD, so the low bits are the write address
    final_word = load_last || (count_q[D-1:0] == {D{1'b1}});
    count_d    = count_q + 1'b1;
`ifdef INSTR_PARITY_EN
    wr_entry   = {load_parity, load_data};
`else
    wr_entry   = load_data;
`endif
    rd_entry   = core[programCounter];
    // Addresses beyond the loaded program read as FILL, hiding stale contents from earlier loads
    in_range   = ({1'b0, programCounter} < count_q);
  end

  // Load FSM: IDLE -> LOAD on start, LOAD -> DONE on last word or full memory; outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      load_ready_q <= 1'b0;
      loaded_q     <= 1'b0;
      count_q      <= '0;
      load_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= LOAD;
            load_ready_q <= 1'b1;
          end
        end
        LOAD: begin
          if (xfer) begin
            count_q <= count_d;
`ifdef INSTR_PARITY_EN
            if ((^load_data) != load_parity) load_err_q <= 1'b1;
`endif
            if (final_word) begin
              state_q      <= DONE;
              load_ready_q <= 1'b0;
              loaded_q     <= 1'b1;
            end
          end
        end
        DONE: begin
          // Load-once: start is ignored; words pushed at a full memory are dropped and flagged
          if (load_valid && count_q[D]) load_err_q <= 1'b1;
        end
        default: begin
          state_q      <= IDLE;
          load_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Program storage: written sequentially during LOAD, never cleared
  always_ff @(posedge clk) begin
    if (xfer && !reset) core[count_q[D-1:0]] <= wr_entry;
  end

  // Registered fetch: one result per cycle, value held when no fetch is issued
  always_ff @(posedge clk) begin
    if (reset) begin
      code_q       <= FILL;
      code_valid_q <= 1'b0;
`ifdef INSTR_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else if (fetch_en && loaded_q) begin
      code_valid_q <= 1'b1;
      if (in_range) begin
        code_q       <= rd_entry[W-1:0];
`ifdef INSTR_PARITY_EN
        parity_err_q <= ^rd_entry;
`endif
      end else begin
        code_q       <= FILL;
`ifdef INSTR_PARITY_EN
        parity_err_q <= 1'b0;
`endif
      end
    end else begin
      code_valid_q <= 1'b0;
    end
  end

  assign load_ready  = load_ready_q;
  assign loaded      = loaded_q;
  assign load_count  = count_q;
  assign load_err    = load_err_q;
  assign machineCode = code_q;
  assign code_valid  = code_valid_q;
`ifdef INSTR_PARITY_EN
  assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_instruction_stream_rom.sv
// tb/tb_instruction_stream_rom.sv - directed and randomized checks of instruction_stream_rom against a queue model
module tb_instruction_stream_rom;
  localparam int W  = 9;
  localparam int D  = 12;
  localparam int DS = 3;
  localparam logic [W-1:0] FILL_V = '0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, lv, ll, fe;
  logic [W-1:0] ld;
  logic [D-1:0] pc;
  logic         lr, cv, ldd, le;
  logic [W-1:0] mc;
  logic [D:0]   lc;
`ifdef INSTR_PARITY_EN
  logic         lp, pe;
`endif

  logic          s_reset, s_start, s_lv, s_ll, s_fe;
  logic [W-1:0]  s_ld;
  logic [DS-1:0] s_pc;
  logic          s_lr, s_cv, s_ldd, s_le;
  logic [W-1:0]  s_mc;
  logic [DS:0]   s_lc;
`ifdef INSTR_PARITY_EN
  logic          s_lp, s_pe;
`endif

  instruction_stream_rom #(.W(W), .D(D), .FILL(FILL_V)) u_dut (
    .clk(clk), .reset(reset), .start(start), .load_valid(lv), .load_data(ld), .load_last(ll),
`ifdef INSTR_PARITY_EN
    .load_parity(lp), .parity_err(pe),
`endif
    .load_ready(lr), .programCounter(pc), .fetch_en(fe), .machineCode(mc), .code_valid(cv),
    .loaded(ldd), .load_count(lc), .load_err(le)
  );

  instruction_stream_rom #(.W(W), .D(DS), .FILL(FILL_V)) u_small (
    .clk(clk), .reset(s_reset), .start(s_start), .load_valid(s_lv), .load_data(s_ld), .load_last(s_ll),
`ifdef INSTR_PARITY_EN
    .load_parity(s_lp), .parity_err(s_pe),
`endif
    .load_ready(s_lr), .programCounter(s_pc), .fetch_en(s_fe), .machineCode(s_mc), .code_valid(s_cv),
    .loaded(s_ldd), .load_count(s_lc), .load_err(s_le)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word to the big instance and wait (bounded) until it is taken
  task automatic push(input logic [W-1:0] w, input logic last);
    int guard;
    guard = 0;
    lv = 1'b1; ld = w; ll = last;
`ifdef INSTR_PARITY_EN
    lp = ^w;
`endif
    while (!lr && guard < 20) begin
      step();
      guard++;
    end
    check("push_ready", {31'd0, lr}, 32'd1);
    step();
    lv = 1'b0; ll = 1'b0;
  endtask

  task automatic s_push(input logic [W-1:0] w);
    s_lv = 1'b1; s_ld = w; s_ll = 1'b0;
`ifdef INSTR_PARITY_EN
    s_lp = ^w;
`endif
    check("s_push_ready", {31'd0, s_lr}, 32'd1);
    step();
    s_lv = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; lv = 1'b0; fe = 1'b0;
    step();
    reset = 1'b0;
  endtask

  logic [W-1:0] model[$];
  logic [W-1:0] small_words[8];
  logic [W-1:0] exp_mc;
  int           n_words;
  int           gap;
  logic         f;
  logic [D-1:0] a;

  initial begin
    reset = 1'b1; start = 1'b0; lv = 1'b0; ld = '0; ll = 1'b0; fe = 1'b0; pc = '0;
    s_reset = 1'b1; s_start = 1'b0; s_lv = 1'b0; s_ld = '0; s_ll = 1'b0; s_fe = 1'b0; s_pc = '0;
`ifdef INSTR_PARITY_EN
    lp = 1'b0; s_lp = 1'b0;
`endif
    step();
    step();

    // Reset state
    check("rst_load_ready", {31'd0, lr}, 32'd0);
    check("rst_loaded", {31'd0, ldd}, 32'd0);
    check("rst_load_count", {19'd0, lc}, 32'd0);
    check("rst_load_err", {31'd0, le}, 32'd0);
    check("rst_machineCode", {23'd0, mc}, {23'd0, FILL_V});
    check("rst_code_valid", {31'd0, cv}, 32'd0);

    // Test 1: four-word program, fetch PC=2
    reset = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    check("t1_ready_in_load", {31'd0, lr}, 32'd1);
    push(9'h07E, 1'b0);
    push(9'h0CC, 1'b0);
    push(9'h0F4, 1'b0);
    check("t1_not_loaded_yet", {31'd0, ldd}, 32'd0);
    check("t1_count3", {19'd0, lc}, 32'd3);
    push(9'h1DE, 1'b1);
    check("t1_loaded", {31'd0, ldd}, 32'd1);
    check("t1_count4", {19'd0, lc}, 32'd4);
    check("t1_ready_done", {31'd0, lr}, 32'd0);
    fe = 1'b1; pc = 12'd2;
    step();
    check("t1_mc_pc2", {23'd0, mc}, 32'h0F4);
    check("t1_cv_pc2", {31'd0, cv}, 32'd1);

    // Test 2: back-to-back PC=3 then PC=10 (beyond program -> FILL)
    pc = 12'd3;
    step();
    check("t2_mc_pc3", {23'd0, mc}, 32'h1DE);
    check("t2_cv_pc3", {31'd0, cv}, 32'd1);
    pc = 12'd10;
    step();
    check("t2_mc_pc10", {23'd0, mc}, {23'd0, FILL_V});
    check("t2_cv_pc10", {31'd0, cv}, 32'd1);
    fe = 1'b0;
    step();
    check("t2_cv_idle", {31'd0, cv}, 32'd0);
    check("t2_mc_hold", {23'd0, mc}, {23'd0, FILL_V});

    // Short program in DONE: start and stray load_valid are ignored
    start = 1'b1; lv = 1'b1; ld = 9'h111;
    step();
    start = 1'b0; lv = 1'b0;
    check("done_start_ignored", {31'd0, lr}, 32'd0);
    check("done_short_no_err", {31'd0, le}, 32'd0);
    check("done_count_kept", {19'd0, lc}, 32'd4);

    // Test 4: idle mid-load with fetch_en asserted during LOAD
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    push(9'h0AA, 1'b0);
    push(9'h0BB, 1'b0);
    fe = 1'b1; pc = 12'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_count_hold", {19'd0, lc}, 32'd2);
      check("t4_cv_low", {31'd0, cv}, 32'd0);
    end
    fe = 1'b0;

    // Test 5: reset mid-load, start+reset together, reload one word
    reset = 1'b1;
    step();
    check("t5_count_cleared", {19'd0, lc}, 32'd0);
    check("t5_ready_cleared", {31'd0, lr}, 32'd0);
    start = 1'b1;
    step();
    check("t5_reset_beats_start", {31'd0, lr}, 32'd0);
    reset = 1'b0;
    step();
    start = 1'b0;
    push(9'h155, 1'b1);
    check("t5_count1", {19'd0, lc}, 32'd1);
    check("t5_loaded", {31'd0, ldd}, 32'd1);
    fe = 1'b1; pc = 12'd1;
    step();
    check("t5_stale_masked", {23'd0, mc}, {23'd0, FILL_V});
    pc = 12'd0;
    step();
    check("t5_pc0", {23'd0, mc}, 32'h155);
    fe = 1'b0;

`ifdef INSTR_PARITY_EN
    // Test 6: bad parity is flagged at load and again at fetch
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    lv = 1'b1; ld = 9'h003; ll = 1'b1; lp = 1'b1;
    step();
    lv = 1'b0; ll = 1'b0;
    check("t6_load_err", {31'd0, le}, 32'd1);
    fe = 1'b1; pc = 12'd0;
    step();
    fe = 1'b0;
    check("t6_parity_err", {31'd0, pe}, 32'd1);
    check("t6_cv", {31'd0, cv}, 32'd1);
    check("t6_mc", {23'd0, mc}, 32'h003);
`endif

    // Test 3: D=3 instance, full-depth load then overflow word
    s_reset = 1'b0; s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      small_words[i] = W'($urandom);
      s_push(small_words[i]);
    end
    check("t3_loaded", {31'd0, s_ldd}, 32'd1);
    check("t3_count8", {28'd0, s_lc}, 32'd8);
    check("t3_no_err_yet", {31'd0, s_le}, 32'd0);
    s_lv = 1'b1; s_ld = 9'h1FF;
    step();
    s_lv = 1'b0;
    check("t3_overflow_err", {31'd0, s_le}, 32'd1);
    check("t3_count_stays", {28'd0, s_lc}, 32'd8);
    s_fe = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_pc = DS'(i);
      step();
      check("t3_readback", {23'd0, s_mc}, {23'd0, small_words[i]});
    end
    s_fe = 1'b0;
    step();
    check("t3_err_sticky", {31'd0, s_le}, 32'd1);

    // Randomized programs with random gaps and random fetch traffic
    for (int r = 0; r < 4; r++) begin
      do_reset();
      model.delete();
      exp_mc = FILL_V;
      n_words = $urandom_range(1, 20);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < n_words; i++) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) step();
        model.push_back(W'($urandom));
        push(model[i], (i == n_words - 1));
      end
      check("rnd_count", {19'd0, lc}, n_words);
      check("rnd_loaded", {31'd0, ldd}, 32'd1);
      for (int k = 0; k < 40; k++) begin
        f = 1'($urandom);
        a = D'($urandom_range(0, 31));
        fe = f; pc = a;
        step();
        if (f) exp_mc = (int'(a) < model.size()) ? model[a] : FILL_V;
        check("rnd_cv", {31'd0, cv}, {31'd0, f});
        check("rnd_mc", {23'd0, mc}, {23'd0, exp_mc});
      end
      fe = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
